// File: rtl/draw_rect.sv
// -----------------------------------------------------------------------------
// draw_rect
//
// Overlays a filled rectangle on a VGA-style timing/pixel stream.
//
// The rectangle's top-left corner (xpos, ypos) is sampled only on the rising
// edge of vblnk_in. Moving the rectangle mid-scan therefore takes effect on the
// next frame instead of tearing the current one. Until the first vblnk edge
// after reset, no rectangle is drawn.
//
// The timing stream and the composited pixel leave the block exactly two clock
// cycles after they enter:
//   stage 1 - registers the stream and rgb_in, and computes the hit (and
//             border) flags;
//   stage 2 - selects the rectangle colour or the background pixel.
//
// Optional feature (macro DRAW_RECT_BORDER_EN):
//   Pixels within 2 px of any rectangle edge use BORDER_COLOR instead of
//   RECT_COLOR. Latency is unchanged. Without the macro, BORDER_COLOR is unused.
//
// Parameters:
//   RECT_W, RECT_H  rectangle size in pixels
//   RECT_COLOR      fill colour (4:4:4 RGB)
//   BORDER_COLOR    border colour (used only with DRAW_RECT_BORDER_EN)
//
// Ports:
//   clk65MHz                  pixel clock
//   rst                       asynchronous active-high reset
//   xpos, ypos                rectangle top-left position (12 bit)
//   hcount_in, vcount_in      pixel / line counters (11 bit)
//   hsync_in, vsync_in        sync signals
//   hblnk_in, vblnk_in        blanking signals
//   rgb_in                    background pixel (12 bit)
//   *_out                     the same stream delayed 2 cycles; rgb_out is
//                             the composited pixel
// -----------------------------------------------------------------------------
module draw_rect #(
    parameter int          RECT_W       = 64,
    parameter int          RECT_H       = 64,
    parameter logic [11:0] RECT_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // ---------------------------------------------------------------------
    // Position latch, updated only at the start of vertical blanking
    // ---------------------------------------------------------------------
    logic [11:0] x_lat_reg;
    logic [11:0] y_lat_reg;
    logic        pos_valid_reg;
    logic        vblnk_prev_reg;
    logic        vblnk_rise;

    assign vblnk_rise = vblnk_in & ~vblnk_prev_reg;

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            x_lat_reg      <= '0;
            y_lat_reg      <= '0;
            pos_valid_reg  <= 1'b0;
            vblnk_prev_reg <= 1'b0;
        end else begin
            vblnk_prev_reg <= vblnk_in;
            if (vblnk_rise) begin
                x_lat_reg     <= xpos;
                y_lat_reg     <= ypos;
                pos_valid_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Hit test. Everything is widened to 13 bits, so x_lat + RECT_W cannot
    // wrap back into the visible range. A rectangle placed near 4095 simply
    // never matches an 11-bit counter.
    // ---------------------------------------------------------------------
    logic [12:0] hc_ext;
    logic [12:0] vc_ext;
    logic [12:0] x_start;
    logic [12:0] y_start;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        hit_next;

    assign hc_ext  = {2'b00, hcount_in};
    assign vc_ext  = {2'b00, vcount_in};
    assign x_start = {1'b0, x_lat_reg};
    assign y_start = {1'b0, y_lat_reg};
    assign x_end   = x_start + 13'(RECT_W);
    assign y_end   = y_start + 13'(RECT_H);

    assign hit_next = pos_valid_reg & ~hblnk_in & ~vblnk_in
                    & (hc_ext >= x_start) & (hc_ext < x_end)
                    & (vc_ext >= y_start) & (vc_ext < y_end);

`ifdef DRAW_RECT_BORDER_EN
    // The border band is 2 px wide on every side. It only matters when
    // hit_next is also set, so it need not be bounded on the outside.
    logic border_next;
    logic border_s1_reg;

    assign border_next = (hc_ext <  x_start + 13'd2)
                       | (hc_ext >= x_end   - 13'd2)
                       | (vc_ext <  y_start + 13'd2)
                       | (vc_ext >= y_end   - 13'd2);
`endif

    // ---------------------------------------------------------------------
    // Stage 1: register the stream and the hit flag
    // ---------------------------------------------------------------------
    logic [10:0] hcount_s1_reg;
    logic [10:0] vcount_s1_reg;
    logic        hsync_s1_reg;
    logic        vsync_s1_reg;
    logic        hblnk_s1_reg;
    logic        vblnk_s1_reg;
    logic [11:0] rgb_s1_reg;
    logic        hit_s1_reg;

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            hcount_s1_reg <= '0;
            vcount_s1_reg <= '0;
            hsync_s1_reg  <= 1'b0;
            vsync_s1_reg  <= 1'b0;
            hblnk_s1_reg  <= 1'b0;
            vblnk_s1_reg  <= 1'b0;
            rgb_s1_reg    <= '0;
            hit_s1_reg    <= 1'b0;
`ifdef DRAW_RECT_BORDER_EN
            border_s1_reg <= 1'b0;
`endif
        end else begin
            hcount_s1_reg <= hcount_in;
            vcount_s1_reg <= vcount_in;
            hsync_s1_reg  <= hsync_in;
            vsync_s1_reg  <= vsync_in;
            hblnk_s1_reg  <= hblnk_in;
            vblnk_s1_reg  <= vblnk_in;
            rgb_s1_reg    <= rgb_in;
            hit_s1_reg    <= hit_next;
`ifdef DRAW_RECT_BORDER_EN
            border_s1_reg <= border_next;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: colour select and output registers
    // ---------------------------------------------------------------------
    logic [11:0] fill_color;

`ifdef DRAW_RECT_BORDER_EN
    assign fill_color = border_s1_reg ? BORDER_COLOR : RECT_COLOR;
`else
    assign fill_color = RECT_COLOR;
`endif

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s1_reg;
            vcount_out <= vcount_s1_reg;
            hsync_out  <= hsync_s1_reg;
            vsync_out  <= vsync_s1_reg;
            hblnk_out  <= hblnk_s1_reg;
            vblnk_out  <= vblnk_s1_reg;
            rgb_out    <= hit_s1_reg ? fill_color : rgb_s1_reg;
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// -----------------------------------------------------------------------------
// tb_draw_rect
//
// Directed testbench for draw_rect with the default parameters
// (64x64 rectangle, fill 12'hF00, border 12'hFFF).
//
// Each "pixel" vector holds its inputs steady for two clocks and then checks
// the output, which keeps the expected values easy to compute by hand. A
// frame boundary is a vblnk_in pulse.
//
// Define DRAW_RECT_BORDER_EN to check the border-colour build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_draw_rect;

    localparam logic [11:0] FILL = 12'hF00;
`ifdef DRAW_RECT_BORDER_EN
    localparam logic [11:0] EDGE = 12'hFFF;
`else
    localparam logic [11:0] EDGE = 12'hF00;
`endif
    localparam logic [11:0] BG = 12'h0A5;
    localparam int NRND = 200;

    logic        clk65MHz = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int vecs = 0;
    int errs = 0;

    draw_rect dut (
        .clk65MHz  (clk65MHz),
        .rst       (rst),
        .xpos      (xpos),
        .ypos      (ypos),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    always #8 clk65MHz = ~clk65MHz;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold one pixel for two clocks, then check the composited pixel and the
    // delayed counters.
    task automatic px(input int h, input int v, input logic hb,
                      input logic [11:0] bg, input logic [11:0] exp, input string tag);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b0;
        rgb_in    = bg;
        repeat (2) @(posedge clk65MHz);
        #1;
        chk({tag, "/rgb"}, rgb_out, exp);
        chk({tag, "/hcnt"}, 12'(hcount_out), 12'(h));
        chk({tag, "/vcnt"}, 12'(vcount_out), 12'(v));
    endtask

    // Frame boundary. xpos/ypos are applied on the same cycle as the vblnk
    // rising edge and replaced by x_after one cycle later, so only the value
    // present on the edge cycle may be captured.
    task automatic vpulse(input logic [11:0] x, input logic [11:0] y, input logic [11:0] x_after);
        vblnk_in = 1'b1;
        hblnk_in = 1'b1;
        xpos     = x;
        ypos     = y;
        @(posedge clk65MHz);
        #1;
        xpos = x_after;
        @(posedge clk65MHz);
        #1;
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
    endtask

    logic [10:0] hq [NRND];
    logic [10:0] vq [NRND];
    logic [3:0]  cq [NRND];
    logic [11:0] rq [NRND];

    initial begin
        // ---------------- reset state ----------------
        #5;
        chk("rst/rgb", rgb_out, 12'h000);
        chk("rst/hcnt", 12'(hcount_out), 12'h000);
        chk("rst/hblnk", 12'(hblnk_out), 12'h000);
        @(posedge clk65MHz);
        #1;
        rst  = 1'b0;
        xpos = 12'd100;
        ypos = 12'd200;

        // ---------------- frame 1: no latched position yet ----------------
        px(100, 200, 1'b0, BG, BG, "f1_corner");
        px(130, 230, 1'b0, BG, BG, "f1_inside");

        // ---------------- frame 2: rectangle at 100..163 / 200..263 -------
        vpulse(12'd100, 12'd200, 12'd100);
        px(100, 200, 1'b0, BG, EDGE, "f2_tl");
        px(163, 263, 1'b0, BG, EDGE, "f2_br");
        px(130, 230, 1'b0, BG, FILL, "f2_mid");
        px(101, 230, 1'b0, BG, EDGE, "f2_h101");
        px(102, 230, 1'b0, BG, FILL, "f2_h102");
        px(161, 230, 1'b0, BG, FILL, "f2_h161");
        px(162, 230, 1'b0, BG, EDGE, "f2_h162");
        px(130, 201, 1'b0, BG, EDGE, "f2_v201");
        px(130, 202, 1'b0, BG, FILL, "f2_v202");
        px(130, 261, 1'b0, BG, FILL, "f2_v261");
        px(130, 262, 1'b0, BG, EDGE, "f2_v262");
        px( 99, 200, 1'b0, BG, BG,   "f2_left");
        px(164, 200, 1'b0, BG, BG,   "f2_right");
        px(100, 199, 1'b0, BG, BG,   "f2_above");
        px(100, 264, 1'b0, BG, BG,   "f2_below");
        px(130, 230, 1'b1, 12'h123, 12'h123, "f2_hblank");

        // ---------------- mid-frame move at vcount 230 ---------------------
        xpos = 12'd300;
        px(130, 230, 1'b0, BG, FILL, "mv_old_x");
        px(130, 250, 1'b0, BG, FILL, "mv_old_x2");
        px(330, 240, 1'b0, BG, BG,   "mv_new_x_early");
        vpulse(12'd300, 12'd200, 12'd777);
        px(300, 200, 1'b0, BG, EDGE, "f3_tl");
        px(363, 263, 1'b0, BG, EDGE, "f3_br");
        px(330, 230, 1'b0, BG, FILL, "f3_mid");
        px(364, 263, 1'b0, BG, BG,   "f3_right");
        px(130, 230, 1'b0, BG, BG,   "f3_old_gone");

        // ---------------- reset mid-rectangle at vcount 250 ----------------
        px(330, 250, 1'b0, BG, FILL, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async/rgb", rgb_out, 12'h000);
        chk("rst_async/hcnt", 12'(hcount_out), 12'h000);
        chk("rst_async/vcnt", 12'(vcount_out), 12'h000);
        chk("rst_async/hsync", 12'(hsync_out), 12'h000);
        repeat (3) @(posedge clk65MHz);
        #1;
        chk("rst_held/rgb", rgb_out, 12'h000);
        rst = 1'b0;
        @(posedge clk65MHz);
        #1;
        chk("rel1/rgb", rgb_out, 12'h000);
        chk("rel1/hsync", 12'(hsync_out), 12'h000);
        @(posedge clk65MHz);
        #1;
        chk("rel2/rgb", rgb_out, BG);
        chk("rel2/hcnt", 12'(hcount_out), 12'd330);
        chk("rel2/hsync", 12'(hsync_out), 12'h001);
        px(330, 250, 1'b0, BG, BG, "post_rst_norect");
        vpulse(12'd300, 12'd200, 12'd300);
        px(330, 250, 1'b0, BG, FILL, "post_rst_next_frame");

        // ---------------- far position: must not wrap ----------------------
        vpulse(12'd4000, 12'd4000, 12'd4000);
        px(  0,   0, 1'b0, BG, BG, "far_origin");
        px( 30,  30, 1'b0, BG, BG, "far_wrap_zone");
        px(2047, 2047, 1'b0, BG, BG, "far_max");

        // ---------------- random stream: exact 2-cycle delay ---------------
        // Every vblnk edge here re-latches 4000/4000, so no pixel can hit.
        for (int i = 0; i < NRND; i++) begin
            hq[i] = 11'($urandom_range(0, 2047));
            vq[i] = 11'($urandom_range(0, 2047));
            cq[i] = 4'($urandom_range(0, 15));
            rq[i] = 12'($urandom_range(0, 4095));
            hcount_in = hq[i];
            vcount_in = vq[i];
            hsync_in  = cq[i][0];
            vsync_in  = cq[i][1];
            hblnk_in  = cq[i][2];
            vblnk_in  = cq[i][3];
            rgb_in    = rq[i];
            @(posedge clk65MHz);
            #1;
            if (i >= 1) begin
                chk("rnd/hcnt",  12'(hcount_out), 12'(hq[i-1]));
                chk("rnd/vcnt",  12'(vcount_out), 12'(vq[i-1]));
                chk("rnd/hsync", 12'(hsync_out),  12'(cq[i-1][0]));
                chk("rnd/vsync", 12'(vsync_out),  12'(cq[i-1][1]));
                chk("rnd/hblnk", 12'(hblnk_out),  12'(cq[i-1][2]));
                chk("rnd/vblnk", 12'(vblnk_out),  12'(cq[i-1][3]));
                chk("rnd/rgb",   rgb_out,         rq[i-1]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
